// File: rtl/handle_pkg.sv
// handle_pkg: definitions shared by the handle translator and the
// memory request queue that sits directly downstream of it.
//   ADDR_WIDTH / HNDL_WIDTH : default bus and handle widths
//   OP_*                    : translated op encodings (3..7 are illegal)
//   req_t                   : one translated request {op, address, data}
//   is_legal_op()           : true for the ops that are queued (READ, WRITE)
package handle_pkg;

  localparam int ADDR_WIDTH = 64;
  localparam int HNDL_WIDTH = 3;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;

  typedef struct packed {
    logic [2:0]            op;
    logic [ADDR_WIDTH-1:0] address;
    logic [ADDR_WIDTH-1:0] data;
  } req_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

  function automatic logic is_illegal_op(input logic [2:0] op);
    return op > OP_WRITE;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count.
//   clock, reset : clock and synchronous active-high reset
//   push/wr_data : write request; ignored while full
//   pop/rd_data  : read request; ignored while empty; rd_data shows the head
//   full, empty  : occupancy flags (count == DEPTH / count == 0)
//   count        : current occupancy, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNTW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTRW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTRW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible after it has been written.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/xlat_mem_queue.sv
// xlat_mem_queue: buffers translated READ/WRITE requests, issues them to the
// memory port with valid/ready, tracks outstanding reads and registers the
// returned read data as the response.
//   i_clock, i_reset            : clock, synchronous active-high reset
//   i_op/i_address/i_data       : translated request stream (o_ready = accept)
//   o_bad_op                    : pulse one cycle after an illegal op is dropped
//   o_mem_valid/op/address/data : request to memory; i_mem_ready accepts it
//   i_mem_rvalid/i_mem_rdata    : in-order read data return
//   o_rsp_valid/o_rsp_data      : registered read response
//   o_rsp_err                   : pulse when read data arrives with none outstanding
//   o_count, o_outstanding      : FIFO occupancy, reads in flight
// Build option XLAT_MEMQ_BYPASS_EN: an accepted request arriving at an empty
// FIFO is presented on o_mem_* in the same cycle, and is not stored at all if
// memory takes it immediately. Without it, o_mem_* comes only from registers.
module xlat_mem_queue #(
  parameter int ADDR_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int MAX_RD     = 3
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [2:0]              i_op,
  input  logic [ADDR_WIDTH-1:0]   i_address,
  input  logic [ADDR_WIDTH-1:0]   i_data,
  output logic                    o_ready,
  output logic                    o_bad_op,
  output logic                    o_mem_valid,
  output logic [2:0]              o_mem_op,
  output logic [ADDR_WIDTH-1:0]   o_mem_address,
  output logic [ADDR_WIDTH-1:0]   o_mem_data,
  input  logic                    i_mem_ready,
  input  logic                    i_mem_rvalid,
  input  logic [ADDR_WIDTH-1:0]   i_mem_rdata,
  output logic                    o_rsp_valid,
  output logic [ADDR_WIDTH-1:0]   o_rsp_data,
  output logic                    o_rsp_err,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic [$clog2(MAX_RD):0] o_outstanding
);

  import handle_pkg::*;

  localparam int PW = 3 + 2 * ADDR_WIDTH;
  localparam int OW = $clog2(MAX_RD) + 1;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [PW-1:0] fifo_head;
  logic [PW-1:0] req_word;

  logic          accept;
  logic          rd_limit;
  logic          issue;
  logic          issue_read;
  logic          rd_return;
  logic          rd_orphan;

  assign req_word = {i_op, i_address, i_data};

  // Reaching MAX_RD (or beyond, if reads already queued drain past it)
  // blocks new requests; queued entries still issue.
  assign rd_limit = (o_outstanding >= OW'(MAX_RD));
  assign o_ready  = ~i_reset & ~fifo_full & ~rd_limit;
  assign accept   = o_ready & is_legal_op(i_op);

  always_comb begin
    o_mem_valid   = ~fifo_empty;
    o_mem_op      = fifo_head[PW-1 -: 3];
    o_mem_address = fifo_head[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
    o_mem_data    = fifo_head[ADDR_WIDTH-1:0];
    fifo_push     = accept;
`ifdef XLAT_MEMQ_BYPASS_EN
    if (fifo_empty && accept) begin
      o_mem_valid   = 1'b1;
      o_mem_op      = i_op;
      o_mem_address = i_address;
      o_mem_data    = i_data;
      fifo_push     = ~i_mem_ready;
    end
`endif
  end

  // Only a stored entry is popped; a bypassed request never entered the FIFO.
  assign fifo_pop   = ~fifo_empty & i_mem_ready;
  assign issue      = o_mem_valid & i_mem_ready;
  assign issue_read = issue & (o_mem_op == OP_READ);
  assign rd_return  = i_mem_rvalid & (o_outstanding != '0);
  assign rd_orphan  = i_mem_rvalid & (o_outstanding == '0);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PW)
  ) u_fifo (
    .clock   (i_clock),
    .reset   (i_reset),
    .push    (fifo_push),
    .wr_data (req_word),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (o_count)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_outstanding <= '0;
    end else begin
      case ({issue_read, rd_return})
        2'b10:   o_outstanding <= o_outstanding + OW'(1);
        2'b01:   o_outstanding <= o_outstanding - OW'(1);
        default: o_outstanding <= o_outstanding;
      endcase
    end
  end

  // Memory returns reads in issue order, so the response is a straight
  // one-cycle register of the return path.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_err   <= 1'b0;
      o_bad_op    <= 1'b0;
    end else begin
      o_rsp_valid <= rd_return;
      if (rd_return) o_rsp_data <= i_mem_rdata;
      o_rsp_err   <= rd_orphan;
      o_bad_op    <= is_illegal_op(i_op);
    end
  end

endmodule

// File: tb/tb_xlat_mem_queue.sv
module tb_xlat_mem_queue;

  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    op;
  logic [AW-1:0] addr;
  logic [AW-1:0] data;
  logic          mem_ready;
  logic          rvalid;
  logic [AW-1:0] rdata;

  logic          o_ready;
  logic          o_bad_op;
  logic          o_mem_valid;
  logic [2:0]    o_mem_op;
  logic [AW-1:0] o_mem_address;
  logic [AW-1:0] o_mem_data;
  logic          o_rsp_valid;
  logic [AW-1:0] o_rsp_data;
  logic          o_rsp_err;
  logic [2:0]    o_count;
  logic [2:0]    o_outstanding;

  int checks   = 0;
  int failures = 0;

  logic [130:0] exp_req[$];
  logic [AW-1:0] exp_rsp[$];

  always #5 clk = ~clk;

  xlat_mem_queue #(.ADDR_WIDTH(AW), .DEPTH(4), .MAX_RD(3)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_op          (op),
    .i_address     (addr),
    .i_data        (data),
    .o_ready       (o_ready),
    .o_bad_op      (o_bad_op),
    .o_mem_valid   (o_mem_valid),
    .o_mem_op      (o_mem_op),
    .o_mem_address (o_mem_address),
    .o_mem_data    (o_mem_data),
    .i_mem_ready   (mem_ready),
    .i_mem_rvalid  (rvalid),
    .i_mem_rdata   (rdata),
    .o_rsp_valid   (o_rsp_valid),
    .o_rsp_data    (o_rsp_data),
    .o_rsp_err     (o_rsp_err),
    .o_count       (o_count),
    .o_outstanding (o_outstanding)
  );

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int expv, input int budget);
    int n = 0;
    while (o_outstanding != 3'(expv) && n < budget) begin
      cyc();
      n++;
    end
    chk("wait_outstanding", o_outstanding, expv);
  endtask

  task automatic drive_req(input logic [2:0] o, input logic [AW-1:0] a, input logic [AW-1:0] d);
    op   = o;
    addr = a;
    data = d;
  endtask

  // Scoreboard side: every issued request and every response is matched
  // against the expectation recorded when the stimulus was driven.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_mem_valid && mem_ready) begin
        if (exp_req.size() == 0) chk("unexpected_mem_req", {o_mem_op, o_mem_address, o_mem_data}, 0);
        else chk("mem_req", {o_mem_op, o_mem_address, o_mem_data}, exp_req.pop_front());
      end
      if (o_rsp_valid) begin
        if (exp_rsp.size() == 0) chk("unexpected_rsp", o_rsp_data, 0);
        else chk("rsp_data", o_rsp_data, exp_rsp.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b0; rvalid = 1'b0; rdata = '0;
    drive_req(3'd0, '0, '0);
    cyc();
    chk("ready_during_reset", o_ready, 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_ready", o_ready, 1);
    chk("rst_count", o_count, 0);
    chk("rst_outstanding", o_outstanding, 0);
    chk("rst_mem_valid", o_mem_valid, 0);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_rsp_data", o_rsp_data, 0);
    chk("rst_rsp_err", o_rsp_err, 0);
    chk("rst_bad_op", o_bad_op, 0);

    // single read round trip
    mem_ready = 1'b1;
    drive_req(3'd1, 64'h10, 64'h0);
    exp_req.push_back({3'd1, 64'h10, 64'h0});
    #1;
    chk("t1_ready", o_ready, 1);
`ifndef XLAT_MEMQ_BYPASS_EN
    chk("t1_no_same_cycle_valid", o_mem_valid, 0);
`endif
    cyc();
    drive_req(3'd0, '0, '0);
    #1;
`ifndef XLAT_MEMQ_BYPASS_EN
    chk("t1_valid", o_mem_valid, 1);
    chk("t1_op", o_mem_op, 1);
    chk("t1_addr", o_mem_address, 64'h10);
    chk("t1_count", o_count, 1);
`endif
    wait_out(1, 5);
    chk("t1_count_drained", o_count, 0);
    rvalid = 1'b1; rdata = 64'hAB;
    exp_rsp.push_back(64'hAB);
    cyc();
    rvalid = 1'b0;
    #1;
    chk("t1_rsp_valid", o_rsp_valid, 1);
    chk("t1_rsp_data", o_rsp_data, 64'hAB);
    chk("t1_outstanding", o_outstanding, 0);

    // fill the FIFO with writes while memory stalls
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_req(3'd2, 64'h100 + 64'(i), 64'hD0 + 64'(i));
      exp_req.push_back({3'd2, 64'h100 + 64'(i), 64'hD0 + 64'(i)});
      #1;
      chk("t2_ready_fill", o_ready, 1);
      cyc();
    end
    drive_req(3'd0, '0, '0);
    #1;
    chk("t2_count_full", o_count, 4);
    chk("t2_ready_full", o_ready, 0);
    chk("t2_head_addr", o_mem_address, 64'h100);
    chk("t2_head_data", o_mem_data, 64'hD0);
    drive_req(3'd2, 64'h999, 64'h0);
    #1;
    chk("t2_fifth_ready", o_ready, 0);
    cyc();
    drive_req(3'd0, '0, '0);
    #1;
    chk("t2_fifth_dropped", o_count, 4);
    chk("t2_head_stable", o_mem_address, 64'h100);
    mem_ready = 1'b1;
    #1;
    chk("t2_full_with_dequeue", o_ready, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t2_drain_count", o_count, 3 - i);
    end

    // outstanding-read limit
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_req(3'd1, 64'h200 + 64'(i), 64'h0);
      exp_req.push_back({3'd1, 64'h200 + 64'(i), 64'h0});
      cyc();
    end
    drive_req(3'd0, '0, '0);
    mem_ready = 1'b1;
    wait_out(3, 10);
    chk("t3_count", o_count, 0);
    chk("t3_ready_rd_limit", o_ready, 0);
    rvalid = 1'b1; rdata = 64'h55;
    exp_rsp.push_back(64'h55);
    #1;
    chk("t3_ready_state_only", o_ready, 0);
    cyc();
    rvalid = 1'b0;
    #1;
    chk("t3_ready_after_return", o_ready, 1);
    chk("t3_outstanding_2", o_outstanding, 2);
    rvalid = 1'b1; rdata = 64'h66;
    exp_rsp.push_back(64'h66);
    cyc();
    rdata = 64'h77;
    exp_rsp.push_back(64'h77);
    cyc();
    rvalid = 1'b0;
    #1;
    chk("t3_outstanding_0", o_outstanding, 0);

    // orphan return and illegal op
    rvalid = 1'b1; rdata = 64'hEE;
    cyc();
    rvalid = 1'b0;
    #1;
    chk("t4_rsp_err", o_rsp_err, 1);
    chk("t4_no_rsp", o_rsp_valid, 0);
    cyc();
    chk("t4_rsp_err_once", o_rsp_err, 0);
    drive_req(3'd5, 64'h555, 64'h5);
    cyc();
    drive_req(3'd0, '0, '0);
    #1;
    chk("t4_bad_op", o_bad_op, 1);
    chk("t4_bad_op_count", o_count, 0);
    cyc();
    chk("t4_bad_op_once", o_bad_op, 0);

    // reset with queued entries and a read in flight
    mem_ready = 1'b1;
    drive_req(3'd1, 64'h300, 64'h0);
    exp_req.push_back({3'd1, 64'h300, 64'h0});
    cyc();
    drive_req(3'd0, '0, '0);
    wait_out(1, 5);
    mem_ready = 1'b0;
    drive_req(3'd2, 64'h400, 64'h1);
    cyc();
    drive_req(3'd2, 64'h401, 64'h2);
    cyc();
    drive_req(3'd0, '0, '0);
    #1;
    chk("t5_count_pre", o_count, 2);
    chk("t5_outstanding_pre", o_outstanding, 1);
    rst = 1'b1;
    #1;
    chk("t5_ready_in_reset", o_ready, 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("t5_count", o_count, 0);
    chk("t5_outstanding", o_outstanding, 0);
    chk("t5_mem_valid", o_mem_valid, 0);
    chk("t5_ready", o_ready, 1);
    rvalid = 1'b1; rdata = 64'hCC;
    cyc();
    rvalid = 1'b0;
    #1;
    chk("t5_late_rsp_err", o_rsp_err, 1);
    chk("t5_late_no_rsp", o_rsp_valid, 0);

`ifdef XLAT_MEMQ_BYPASS_EN
    mem_ready = 1'b1;
    drive_req(3'd2, 64'h20, 64'h77);
    exp_req.push_back({3'd2, 64'h20, 64'h77});
    #1;
    chk("t6_bypass_valid", o_mem_valid, 1);
    chk("t6_bypass_addr", o_mem_address, 64'h20);
    cyc();
    drive_req(3'd0, '0, '0);
    #1;
    chk("t6_bypass_count", o_count, 0);
`endif

    cyc();
    chk("req_scoreboard_empty", exp_req.size(), 0);
    chk("rsp_scoreboard_empty", exp_rsp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
